// File: rtl/lsu_align_if.sv
// Request/response and bridge-side transaction signals of the lsu_align stage.
// The slave modport is the alignment stage; the master modport is the CPU plus bridge.
interface lsu_align_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_size_i;
   logic                  req_unsigned_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;
   logic [ADDR_WIDTH-1:0] transaction_addr_o;
   logic [DATA_WIDTH-1:0] transaction_data_o;
   logic [1:0]            transaction_size_o;
   logic                  transaction_we_o;
   logic                  transaction_start_o;
   logic                  transaction_clear_ready_o;
   logic [DATA_WIDTH-1:0] transaction_data_i;
   logic                  transaction_ready_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  transaction_data_i, transaction_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output transaction_addr_o, transaction_data_o, transaction_size_o,
      output transaction_we_o, transaction_start_o, transaction_clear_ready_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output transaction_data_i, transaction_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  transaction_addr_o, transaction_data_o, transaction_size_o,
      input  transaction_we_o, transaction_start_o, transaction_clear_ready_o
   );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment stage: turns byte/half/word CPU requests into word-only bridge transactions.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with rsp_err_o instead of rounding the offset.
module lsu_align #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   lsu_align_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      WR_WAIT  = 3'd4,
      CLR      = 3'd5,
      RESP     = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  start_q, start_d;
   logic                  clear_q, clear_d;
   logic                  we_q, we_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [DATA_WIDTH-1:0] rword_q, rword_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  store_q, store_d;
   logic                  uns_q, uns_d;
   logic                  wr_phase_q, wr_phase_d;
   logic [1:0]            size_q, size_d;
   logic [1:0]            off_q, off_d;
   logic                  trap;

   // Half lanes are picked with off[1] only and words ignore off, which rounds down to natural alignment.
   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            size,
      input logic [1:0]            off,
      input logic                  uns
   );
      logic [7:0]            b;
      logic [15:0]           h;
      logic [DATA_WIDTH-1:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'd0:    res = {{24{b[7] & ~uns}}, b};
         2'd1:    res = {{16{h[15] & ~uns}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_store(
      input logic [DATA_WIDTH-1:0] word,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [1:0]            size,
      input logic [1:0]            off
   );
      logic [DATA_WIDTH-1:0] res;
      res = word;
      case (size)
         2'd0:    res[{off, 3'b000} +: 8]     = wdata[7:0];
         2'd1:    res[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: res = wdata;
      endcase
      return res;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   // Half needs addr[0]==0; word (size 2 or 3) needs addr[1:0]==0.
   always_comb begin
      case (bus.req_size_i)
         2'd0:    trap = 1'b0;
         2'd1:    trap = bus.req_addr_i[0];
         default: trap = (bus.req_addr_i[1:0] != 2'b00);
      endcase
   end
`else
   assign trap = 1'b0;
`endif

   // Next-state and datapath updates; all request fields are frozen at acceptance.
   always_comb begin
      state_d     = state_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      tx_addr_d   = tx_addr_q;
      tx_data_d   = tx_data_q;
      rword_d     = rword_q;
      wdata_d     = wdata_q;
      store_d     = store_q;
      uns_d       = uns_q;
      wr_phase_d  = wr_phase_q;
      size_d      = size_q;
      off_d       = off_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               store_d    = bus.req_we_i;
               size_d     = bus.req_size_i;
               uns_d      = bus.req_unsigned_i;
               off_d      = bus.req_addr_i[1:0];
               wdata_d    = bus.req_wdata_i;
               tx_addr_d  = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
               rsp_err_d  = trap;
               wr_phase_d = 1'b0;
               if (trap) begin
                  state_d = RESP;
               end else if (bus.req_we_i && bus.req_size_i[1]) begin
                  tx_data_d  = bus.req_wdata_i;
                  wr_phase_d = 1'b1;
                  state_d    = WR_ISSUE;
               end else begin
                  state_d = RD_ISSUE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (bus.transaction_ready_i) begin
               rword_d = bus.transaction_data_i;
               state_d = CLR;
            end else begin
               state_d = RD_WAIT;
            end
         end
         WR_ISSUE: state_d = WR_WAIT;
         WR_WAIT: begin
            if (bus.transaction_ready_i) begin
               state_d = CLR;
            end else begin
               state_d = WR_WAIT;
            end
         end
         CLR: begin
            if (store_q && !wr_phase_q) begin
               tx_data_d  = merge_store(rword_q, wdata_q, size_q, off_q);
               wr_phase_d = 1'b1;
               state_d    = WR_ISSUE;
            end else begin
               if (!store_q) begin
                  rsp_rdata_d = extract_load(rword_q, size_q, off_q, uns_q);
               end else begin
                  rsp_rdata_d = rsp_rdata_q;
               end
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered copies decoded from the next state, so each is a clean Moore output.
   always_comb begin
      ready_d     = (state_d == IDLE);
      start_d     = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
      clear_d     = (state_d == CLR);
      rsp_valid_d = (state_d == RESP);
      we_d        = (state_d == WR_ISSUE) || (state_d == WR_WAIT);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         start_q     <= 1'b0;
         clear_q     <= 1'b0;
         we_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
         tx_addr_q   <= {ADDR_WIDTH{1'b0}};
         tx_data_q   <= {DATA_WIDTH{1'b0}};
         rword_q     <= {DATA_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         store_q     <= 1'b0;
         uns_q       <= 1'b0;
         wr_phase_q  <= 1'b0;
         size_q      <= 2'd0;
         off_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         start_q     <= start_d;
         clear_q     <= clear_d;
         we_q        <= we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         tx_addr_q   <= tx_addr_d;
         tx_data_q   <= tx_data_d;
         rword_q     <= rword_d;
         wdata_q     <= wdata_d;
         store_q     <= store_d;
         uns_q       <= uns_d;
         wr_phase_q  <= wr_phase_d;
         size_q      <= size_d;
         off_q       <= off_d;
      end
   end

   assign bus.req_ready_o               = ready_q;
   assign bus.rsp_valid_o               = rsp_valid_q;
   assign bus.rsp_err_o                 = rsp_err_q;
   assign bus.rsp_rdata_o               = rsp_rdata_q;
   assign bus.transaction_addr_o        = tx_addr_q;
   assign bus.transaction_data_o        = tx_data_q;
   assign bus.transaction_size_o        = 2'd2;
   assign bus.transaction_we_o          = we_q;
   assign bus.transaction_start_o       = start_q;
   assign bus.transaction_clear_ready_o = clear_q;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed table, misalignment, reset mid-read, and random requests
// compared against an arithmetic reference model; a negedge bridge model answers transactions.
module tb_lsu_align;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   lsu_align_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   lsu_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bridge model ----------------
   int          ack_delay  = 0;
   logic [31:0] slave_word = 32'd0;
   int          start_cnt  = 0;
   int          clr_cnt    = 0;
   int          rd_cnt     = 0;
   int          wr_cnt     = 0;
   int          dbl_start  = 0;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic        prev_start = 1'b0;
   logic        pend       = 1'b0;
   logic        p_we       = 1'b0;
   int          cnt        = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         bus.transaction_ready_i = 1'b0;
         bus.transaction_data_i  = 32'd0;
         pend       = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (bus.transaction_clear_ready_o) begin
            bus.transaction_ready_i = 1'b0;
            bus.transaction_data_i  = $urandom;
            clr_cnt++;
         end
         if (bus.transaction_start_o) begin
            start_cnt++;
            if (prev_start) dbl_start++;
            pend = 1'b1;
            cnt  = ack_delay + 2;
            p_we = bus.transaction_we_o;
            if (p_we) begin
               wr_cnt++;
               wr_addr = bus.transaction_addr_o;
               wr_data = bus.transaction_data_o;
            end else begin
               rd_cnt++;
               rd_addr = bus.transaction_addr_o;
            end
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0;
               bus.transaction_ready_i = 1'b1;
               if (!p_we) bus.transaction_data_i = slave_word;
            end
         end
         prev_start = bus.transaction_start_o;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [31:0] word, input int size, input bit uns, input int off);
      logic [31:0] v;
      if (size == 0) begin
         v = (word >> (8 * off)) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wdata, input int size, input int off);
      logic [31:0] mask;
      int          sh;
      if (size >= 2) return wdata;
      sh   = (size == 0) ? 8 * off : 16 * (off / 2);
      mask = ((size == 0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      return (word & ~mask) | ((wdata << sh) & mask);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // One request: drive, wait bounded for rsp_valid_o, compare against the supplied expectations.
   task automatic run_and_check(input string name, input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                                input int delay, input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_rd, input int exp_wr, input logic [31:0] exp_wword);
      int  n, lat, rdy_hi, s0, c0, r0, w0;
      bit  got;
      logic [31:0] act_rdata;
      logic        act_err;
      ack_delay  = delay;
      slave_word = word;
      n = 0;
      while (!bus.req_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, ".idle_ready"}, 32'(bus.req_ready_o), 32'd1);
      s0 = start_cnt; c0 = clr_cnt; r0 = rd_cnt; w0 = wr_cnt;
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      @(negedge clk);
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'($urandom);
      bus.req_size_i     = 2'($urandom);
      bus.req_unsigned_i = 1'($urandom);
      bus.req_addr_i     = $urandom;
      bus.req_wdata_i    = $urandom;
      lat = 1; got = 1'b0; rdy_hi = 0;
      act_rdata = 32'd0; act_err = 1'b0;
      while (!got && lat < 100) begin
         if (bus.rsp_valid_o) begin
            got       = 1'b1;
            act_rdata = bus.rsp_rdata_o;
            act_err   = bus.rsp_err_o;
         end else begin
            if (bus.req_ready_o) rdy_hi++;
            @(negedge clk);
            lat++;
         end
      end
      check({name, ".rsp_seen"}, 32'(got), 32'd1);
      check({name, ".latency"}, 32'(lat), 32'(exp_lat));
      check({name, ".rdata"}, act_rdata, exp_rdata);
      check({name, ".err"}, 32'(act_err), 32'(exp_err));
      check({name, ".ready_low"}, 32'(rdy_hi), 32'd0);
      check({name, ".reads"}, 32'(rd_cnt - r0), 32'(exp_rd));
      check({name, ".writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
      check({name, ".clears"}, 32'(clr_cnt - c0), 32'(start_cnt - s0));
      if (exp_rd > 0) check({name, ".rd_addr"}, rd_addr, addr & 32'hFFFF_FFFC);
      if (exp_wr > 0) begin
         check({name, ".wr_addr"}, wr_addr, addr & 32'hFFFF_FFFC);
         check({name, ".wr_data"}, wr_data, exp_wword);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      int          delay;
      logic [31:0] exp_rdata;
      logic [31:0] exp_wword;
      int          exp_lat;
   } vec_t;

   vec_t        vt[10];
   logic [31:0] last_rdata;

   initial begin
      #400000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80AA55CC, 0, 32'hFFFFFF80, 32'h0,        5};
      vt[1] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80011234, 0, 32'h00008001, 32'h0,        5};
      vt[2] = '{1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFF5A, 32'h11223344, 0, 32'h00008001, 32'h11225A44, 9};
      vt[3] = '{1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0BADF00D, 3, 32'h00008001, 32'hDEADBEEF, 8};
      vt[4] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'h1234F678, 0, 32'h000000F6, 32'h0,        5};
      vt[5] = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'h0000F00D, 2, 32'hFFFFF00D, 32'h0,        7};
      vt[6] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'hCAFEBABE, 0, 32'hCAFEBABE, 32'h0,        5};
      vt[7] = '{1'b1, 2'd1, 1'b0, 32'h502, 32'hAAAA1234, 32'h55667788, 0, 32'hCAFEBABE, 32'h12347788, 9};
      vt[8] = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h0000007F, 1, 32'h0000007F, 32'h0,        6};
      vt[9] = '{1'b1, 2'd0, 1'b0, 32'h600, 32'h000000EE, 32'hFFFFFFFF, 2, 32'h0000007F, 32'hFFFFFFEE, 13};

      rst_n              = 1'b0;
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'd0;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 32'd0;
      bus.req_wdata_i    = 32'd0;
      repeat (3) @(negedge clk);
      check("rst.ready", 32'(bus.req_ready_o), 32'd1);
      check("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rst.rsp_err", 32'(bus.rsp_err_o), 32'd0);
      check("rst.rsp_rdata", bus.rsp_rdata_o, 32'd0);
      check("rst.start", 32'(bus.transaction_start_o), 32'd0);
      check("rst.clear", 32'(bus.transaction_clear_ready_o), 32'd0);
      check("rst.we", 32'(bus.transaction_we_o), 32'd0);
      check("rst.addr", bus.transaction_addr_o, 32'd0);
      check("rst.data", bus.transaction_data_o, 32'd0);
      check("rst.size", 32'(bus.transaction_size_o), 32'd2);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_and_check($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
                       vt[i].word, vt[i].delay, vt[i].exp_rdata, 1'b0, vt[i].exp_lat,
                       (!vt[i].we || !vt[i].size[1]) ? 1 : 0, vt[i].we ? 1 : 0, vt[i].exp_wword);
      end
      last_rdata = 32'h0000007F;

`ifdef LSU_MISALIGN_TRAP_EN
      run_and_check("mis_word", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h13579BDF, 0, last_rdata, 1'b1, 1, 0, 0, 32'h0);
`else
      run_and_check("mis_word", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h13579BDF, 0, 32'h13579BDF, 1'b0, 5, 1, 0, 32'h0);
      last_rdata = 32'h13579BDF;
`endif

      // Reset while the read is outstanding: everything drops at once, then a fresh load works.
      begin
         int vhi;
         ack_delay  = 20;
         slave_word = 32'h2468ACE0;
         while (!bus.req_ready_o) @(negedge clk);
         bus.req_valid_i = 1'b1;
         bus.req_we_i    = 1'b0;
         bus.req_size_i  = 2'd2;
         bus.req_addr_i  = 32'h700;
         @(negedge clk);
         bus.req_valid_i = 1'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b0;
         #1;
         check("midrst.start", 32'(bus.transaction_start_o), 32'd0);
         check("midrst.clear", 32'(bus.transaction_clear_ready_o), 32'd0);
         check("midrst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
         check("midrst.ready", 32'(bus.req_ready_o), 32'd1);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         vhi = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) vhi++;
         end
         check("midrst.no_rsp", 32'(vhi), 32'd0);
         last_rdata = 32'd0;
         run_and_check("post_rst", 1'b0, 2'd2, 1'b0, 32'h704, 32'h0, 32'h0F1E2D3C, 0, 32'h0F1E2D3C, 1'b0, 5, 1, 0, 32'h0);
         last_rdata = 32'h0F1E2D3C;
      end

      for (int it = 0; it < 150; it++) begin
         logic        we, uns, mis;
         int          size, off, d, lat, nr, nw;
         logic [31:0] addr, wdata, word, er, ew;
         we    = 1'($urandom_range(0, 1));
         uns   = 1'($urandom_range(0, 1));
         size  = $urandom_range(0, 3);
         addr  = 32'($urandom_range(0, 4095));
         wdata = $urandom;
         word  = $urandom;
         d     = $urandom_range(0, 3);
         off   = addr % 4;
         mis   = (size == 1 && off % 2 != 0) || (size >= 2 && off != 0);
         ew    = 32'd0;
         if (TRAP && mis) begin
            er = last_rdata; lat = 1; nr = 0; nw = 0;
         end else if (!we) begin
            er = ref_load(word, size, uns, off);
            lat = 5 + d; nr = 1; nw = 0;
         end else if (size >= 2) begin
            er = last_rdata; ew = wdata; lat = 5 + d; nr = 0; nw = 1;
         end else begin
            er = last_rdata; ew = ref_store(word, wdata, size, off); lat = 9 + 2 * d; nr = 1; nw = 1;
         end
         run_and_check($sformatf("rnd%0d", it), we, 2'(size), uns, addr, wdata, word, d, er,
                       TRAP && mis, lat, nr, nw, ew);
         last_rdata = er;
      end

      check("end.double_start", 32'(dbl_start), 32'd0);
      check("end.size", 32'(bus.transaction_size_o), 32'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment stage directly upstream of the Wishbone transaction bridge; drives its transaction_* request side.
- Accepts one CPU memory request at a time (byte/half/word, signed/unsigned loads) and issues only word-sized, word-aligned bridge transactions.
- Loads: extracts and sign/zero-extends the addressed lane. Sub-word stores: read-modify-write, one read then one word write.

Parameters:
- ADDR_WIDTH, 32, request/transaction address width.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=treated as word.
- req_unsigned_i  in  1  zero-extend load result.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_WIDTH  load result; valid with rsp_valid_o.
- rsp_err_o  out  1  misalignment error, qualified by rsp_valid_o.
- transaction_addr_o  out  ADDR_WIDTH  word-aligned address to bridge.
- transaction_data_o  out  DATA_WIDTH  write word to bridge.
- transaction_size_o  out  2  constant 2 (word).
- transaction_we_o  out  1  bridge write enable.
- transaction_start_o  out  1  one-cycle start pulse.
- transaction_clear_ready_o  out  1  one-cycle clear pulse.
- transaction_data_i  in  DATA_WIDTH  bridge read data.
- transaction_ready_i  in  1  bridge done flag, sticky until cleared.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - state IDLE; req_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - All transaction_* outputs 0, except transaction_size_o=2.
  - Reset mid-operation abandons the request with no response. The bridge must be reset in the same cycle.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, CLR, RESP.
- req_ready_o=1 only in IDLE. All request fields are registered at acceptance; later changes are ignored.
- IDLE, on acceptance: register off=addr[1:0]. transaction_addr_o <= {addr[ADDR_WIDTH-1:2],2'b00}, held stable until RESP. Next state:
  - load or sub-word store → RD_ISSUE.
  - word store → WR_ISSUE, with transaction_data_o=wdata.
- RD_ISSUE / WR_ISSUE: transaction_start_o=1 for exactly this one cycle; transaction_we_o=0 / 1. Next state RD_WAIT / WR_WAIT.
  - start must never be high for two consecutive cycles, otherwise the bridge re-launches.
- RD_WAIT / WR_WAIT: wait for transaction_ready_i=1, with no timeout.
  - In RD_WAIT, capture transaction_data_i on that cycle only.
  - Next state CLR.
- CLR: transaction_clear_ready_o=1 for one cycle. Next state:
  - load → RESP.
  - sub-word store after its read → WR_ISSUE, with transaction_data_o = merged word.
  - after a write → RESP.
  - transaction_ready_i is guaranteed low on entry to the following ISSUE.
- RESP: rsp_valid_o=1 for one cycle → IDLE.
- Load extraction (little-endian):
  - byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16]; word = rdata.
  - Sign-extend from bit 7/15 unless req_unsigned_i=1.
  - rsp_rdata_o holds its value until the next RESP; stores leave it unchanged.
- Store merge:
  - byte replaces lane off with wdata[7:0].
  - half replaces lanes {2*off[1], 2*off[1]+1} with wdata[15:0].
  - other lanes come from the read word.
- Latency, slave acking in the first strobe cycle, acceptance at edge E0:
  - load / word store: rsp_valid_o in cycle 5 after E0.
  - sub-word store: cycle 9.
- Misaligned = half with addr[0]=1, or word with addr[1:0]≠0. Handling is set by the optional feature.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request issues no bridge transaction. Next cycle RESP with rsp_err_o=1; rsp_rdata_o unchanged.
- Undefined: the offset is rounded down to natural alignment (half ignores addr[0], word ignores addr[1:0]). rsp_err_o is tied 0.

Test Plan:
- Load byte, addr 0x103, unsigned=0, bus word 0x80AA55CC → one read at 0x100; rsp_rdata_o=0xFFFFFF80; rsp_valid_o in cycle 5.
- Load half, addr 0x102, unsigned=1, word 0x8001_1234 → rsp_rdata_o=0x00008001.
- Store byte 0x5A to 0x201, memory 0x11223344 → read then write 0x11225A44 at 0x200. Start pulses exactly twice, each one cycle; clear pulses twice.
- Store word 0xDEADBEEF to 0x300 with slave ack delayed 3 cycles → single write, we=1; rsp_valid_o in cycle 8; req_ready_o=0 throughout.
- Load word, addr 0x102, with LSU_MISALIGN_TRAP_EN → no start pulse; rsp_valid_o=1, rsp_err_o=1 in cycle 1. Without the macro → read of 0x100, rsp_err_o=0.
- rst_n_i low during RD_WAIT → start, clear and rsp_valid_o immediately 0; after release req_ready_o=1 and a new load completes normally.
